mod3_reduce_pipe: RTL

Pipelined, multi-lane reducer. Each cycle it accepts LANES unsigned IN_W-bit coefficients and returns each value mod 3 as a 2-bit residue, with valid/ready flow control. It sits between the Encaps polynomial multiplier outputs and the S3/packing logic. It replaces per-byte combinational mod-3 trees with a registered reduction tree whose depth scales with IN_W.

---
 rtl/mod3_pkg.sv | 16 +
 rtl/mod3_add2.sv | 15 +
 rtl/mod3_reduce_pipe.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mod3_pkg.sv
// Shared residue types and constants for the mod-3 reduction pipeline.
package mod3_pkg;

    typedef logic [1:0] res3_t;

    localparam res3_t RES_ZERO = 2'b00;
    localparam res3_t RES_ONE  = 2'b01;
    localparam res3_t RES_TWO  = 2'b10;
    localparam res3_t RES_NEG1 = 2'b11;

    // Number of pairwise-add levels needed to fold IN_W/2 base-4 digits to one residue.
    function automatic int MOD3_LEVELS(input int in_w);
        return $clog2(in_w / 2);
    endfunction

endpackage

// File: rtl/mod3_add2.sv
// Combinational residue adder: s = (a + b) mod 3 for canonical residues 0..2.
module mod3_add2
    import mod3_pkg::*;
(
    input  res3_t a,
    input  res3_t b,
    output res3_t s
);

    logic [2:0] t;

    assign t = {1'b0, a} + {1'b0, b};
    assign s = (t >= 3'd3) ? res3_t'(t - 3'd3) : t[1:0];

endmodule

// File: rtl/mod3_reduce_pipe.sv
// Multi-lane pipelined mod-3 reducer with global-enable valid/ready flow control.
// Optional build macro MOD3_CENTERED_EN: emit residue 2 as 2'b11 (centered lift -1).
module mod3_reduce_pipe
    import mod3_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int LANES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*IN_W-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*LANES-1:0]    out_res,
    output logic                  out_last
);

    localparam int NDIG = IN_W / 2;
    localparam int D    = MOD3_LEVELS(IN_W);

    if ((IN_W < 4) || (IN_W > 64) || ((IN_W & (IN_W - 1)) != 0)) begin : g_bad_in_w
        $error("mod3_reduce_pipe: IN_W must be a power of two in 4..64");
    end
    if ((LANES < 1) || (LANES > 16)) begin : g_bad_lanes
        $error("mod3_reduce_pipe: LANES must be in 1..16");
    end

    logic en;

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    // Level 0: split into base-4 digits; since 4 == 1 mod 3, digit 3 folds to 0.
    res3_t dig [LANES][NDIG];

    for (genvar i = 0; i < LANES; i++) begin : g_dig_lane
        for (genvar k = 0; k < NDIG; k++) begin : g_dig
            assign dig[i][k] = (in_data[i*IN_W + 2*k +: 2] == 2'd3)
                             ? RES_ZERO : res3_t'(in_data[i*IN_W + 2*k +: 2]);
        end
    end

    for (genvar l = 1; l <= D; l++) begin : g_lvl
        localparam int CNT = NDIG >> l;

        res3_t src   [LANES][2*CNT];
        res3_t sum   [LANES][CNT];
        res3_t res_p [LANES][CNT];
        logic  src_vld;
        logic  src_last;
        logic  vld_p;
        logic  last_p;

        if (l == 1) begin : g_from_in
            assign src      = dig;
            assign src_vld  = in_valid;
            assign src_last = in_last;
        end else begin : g_from_prev
            assign src      = g_lvl[l-1].res_p;
            assign src_vld  = g_lvl[l-1].vld_p;
            assign src_last = g_lvl[l-1].last_p;
        end

        for (genvar i = 0; i < LANES; i++) begin : g_lane
            for (genvar k = 0; k < CNT; k++) begin : g_add
                mod3_add2 u_add (
                    .a (src[i][2*k]),
                    .b (src[i][2*k+1]),
                    .s (sum[i][k])
                );
            end
        end

        // Level l register boundary: valid, last and residues advance together on en.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_p <= 1'b0;
            end else if (en) begin
                vld_p <= src_vld;
            end
        end

        if (l == D) begin : g_out_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LANES; i++) begin
                        for (int k = 0; k < CNT; k++) begin
                            res_p[i][k] <= RES_ZERO;
                        end
                    end
                    last_p <= 1'b0;
                end else if (en) begin
                    res_p  <= sum;
                    last_p <= src_last;
                end
            end
        end else begin : g_mid_reg
            always_ff @(posedge clk) begin
                if (en) begin
                    res_p  <= sum;
                    last_p <= src_last;
                end
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_out
        res3_t r;

        assign r = g_lvl[D].res_p[i][0];
`ifdef MOD3_CENTERED_EN
        assign out_res[2*i +: 2] = (r == RES_TWO) ? RES_NEG1 : r;
`else
        assign out_res[2*i +: 2] = r;
`endif
    end

    assign out_valid = g_lvl[D].vld_p;
    assign out_last  = g_lvl[D].last_p;

endmodule
